// File: rtl/poly_param_fetch.sv
// poly_param_fetch: walks one object-list entry (strip, triangle array or
// quad array) in VRAM, gathers header and vertex X/Y/Z words one read at a
// time, and hands complete triangles to setup over a valid/ready handshake.
module poly_param_fetch #(
  parameter int ADDR_W = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_render_poly,
  input  logic [ADDR_W-1:0] i_poly_addr,
  input  logic [31:0]       i_opb_word,
  input  logic              i_two_volume,
  output logic              o_busy,
  output logic              o_pf_vram_rd,
  output logic [ADDR_W-1:0] o_pf_vram_addr,
  input  logic [31:0]       i_pf_vram_din,
  input  logic              i_pf_vram_valid,
  output logic              o_tri_valid,
  input  logic              i_tri_ready,
  output logic [31:0]       o_tri_isp,
  output logic [31:0]       o_tri_tsp,
  output logic [31:0]       o_tri_tcw,
  output logic [31:0]       o_tri_v0x,
  output logic [31:0]       o_tri_v0y,
  output logic [31:0]       o_tri_v0z,
  output logic [31:0]       o_tri_v1x,
  output logic [31:0]       o_tri_v1y,
  output logic [31:0]       o_tri_v1z,
  output logic [31:0]       o_tri_v2x,
  output logic [31:0]       o_tri_v2y,
  output logic [31:0]       o_tri_v2z,
  output logic              o_poly_drawn
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HDR = 3'd1, S_VTX = 3'd2, S_EMIT = 3'd3, S_NEXT = 3'd4, S_DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {M_STRIP = 2'd0, M_TRI = 2'd1, M_QUAD = 2'd2} mode_t;

  // Highest enabled strip triangle index.
  function automatic logic [2:0] f_hmax(input logic [5:0] m);
    logic [2:0] h;
    h = 3'd0;
    for (int n = 0; n < 6; n++) begin
      if (m[n]) h = 3'(n);
      else h = h;
    end
    return h;
  endfunction

  state_t            r_state;
  mode_t             r_mode;
  logic [5:0]        r_mask;
  logic [2:0]        r_hmax;
  logic [2:0]        r_hdr_words;
  logic [4:0]        r_stride;
  logic [3:0]        r_prim_left;
  logic              r_pending;
  logic [1:0]        r_word_idx;
  logic [3:0]        r_vcnt;
  logic [ADDR_W-1:0] r_vaddr;
  logic [31:0]       r_h0, r_h1, r_h2;
  logic [31:0]       r_nx, r_ny;
  logic [95:0]       r_w1, r_w2, r_va;

  mode_t             w_dec_mode;
  logic              w_dec_go;
  logic [5:0]        w_dec_mask;
  logic              w_dv;
  logic [4:0]        w_dec_stride;
  logic [ADDR_W-1:0] w_word_addr_next;
  logic [ADDR_W-1:0] w_hdr_done_addr;
  logic [ADDR_W-1:0] w_vtx_done_addr;
  logic [95:0]       w_new_vtx;
  logic [3:0]        w_tri_idx;
  logic [7:0]        w_mask_sh;
  logic              w_emit;
  logic              w_odd;
  logic [95:0]       w_t0, w_t1;
  logic              w_next_done;
  logic              w_next_hdr;
  logic              w_unused_bits;

  assign w_unused_bits = &{1'b0, i_opb_word[20:0]};

  // Decode the OL word and derive addressing / triangle-assembly helpers.
  always_comb begin
    w_dec_mode = M_STRIP;
    w_dec_go   = 1'b0;
    for (int n = 0; n < 6; n++) w_dec_mask[n] = i_opb_word[30-n];
    if (i_opb_word[31] == 1'b0) begin
      w_dec_mode = M_STRIP;
      w_dec_go   = |w_dec_mask;
    end else if (i_opb_word[30:29] == 2'b00) begin
      w_dec_mode = M_TRI;
      w_dec_go   = 1'b1;
    end else if (i_opb_word[30:29] == 2'b01) begin
      w_dec_mode = M_QUAD;
      w_dec_go   = 1'b1;
    end else begin
      w_dec_mode = M_STRIP;
      w_dec_go   = 1'b0;
    end
    w_dv         = i_opb_word[24] & i_two_volume;
    w_dec_stride = 5'd3 + (w_dv ? {1'b0, i_opb_word[23:21], 1'b0} : {2'b00, i_opb_word[23:21]});

    w_word_addr_next = r_vaddr + ADDR_W'({r_word_idx + 2'd1, 2'b00});
    w_hdr_done_addr  = r_vaddr + ADDR_W'({r_hdr_words, 2'b00});
    w_vtx_done_addr  = r_vaddr + ADDR_W'({r_stride, 2'b00});
    w_new_vtx        = {r_nx, r_ny, i_pf_vram_din};

    // Vertex just completed has index r_vcnt; strip triangle n = index-2.
    w_tri_idx = r_vcnt - 4'd2;
    w_mask_sh = {2'b00, r_mask} >> w_tri_idx;
    if (r_mode == M_STRIP) begin
      w_emit = (r_vcnt >= 4'd2) && w_mask_sh[0];
    end else if (r_mode == M_TRI) begin
      w_emit = (r_vcnt == 4'd2);
    end else begin
      w_emit = (r_vcnt == 4'd2) || (r_vcnt == 4'd3);
    end

    // Odd strip triangles swap the first two vertices to keep winding.
    w_odd = (r_mode == M_STRIP) && r_vcnt[0];
    if ((r_mode == M_QUAD) && (r_vcnt == 4'd3)) begin
      w_t0 = r_va;
    end else if (w_odd) begin
      w_t0 = r_w2;
    end else begin
      w_t0 = r_w1;
    end
    w_t1 = w_odd ? r_w1 : r_w2;

    if (r_mode == M_STRIP) begin
      w_next_done = (r_vcnt == ({1'b0, r_hmax} + 4'd3));
      w_next_hdr  = 1'b0;
    end else begin
      w_next_done = ((r_mode == M_TRI) || (r_vcnt == 4'd4)) && (r_prim_left == 4'd0);
      w_next_hdr  = ((r_mode == M_TRI) || (r_vcnt == 4'd4)) && (r_prim_left != 4'd0);
    end
  end

  // Fetch/emit state machine with all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_mode         <= M_STRIP;
      r_mask         <= 6'd0;
      r_hmax         <= 3'd0;
      r_hdr_words    <= 3'd0;
      r_stride       <= 5'd0;
      r_prim_left    <= 4'd0;
      r_pending      <= 1'b0;
      r_word_idx     <= 2'd0;
      r_vcnt         <= 4'd0;
      r_vaddr        <= '0;
      r_h0           <= 32'd0;
      r_h1           <= 32'd0;
      r_h2           <= 32'd0;
      r_nx           <= 32'd0;
      r_ny           <= 32'd0;
      r_w1           <= 96'd0;
      r_w2           <= 96'd0;
      r_va           <= 96'd0;
      o_busy         <= 1'b0;
      o_pf_vram_rd   <= 1'b0;
      o_pf_vram_addr <= '0;
      o_tri_valid    <= 1'b0;
      {o_tri_isp, o_tri_tsp, o_tri_tcw} <= 96'd0;
      {o_tri_v0x, o_tri_v0y, o_tri_v0z} <= 96'd0;
      {o_tri_v1x, o_tri_v1y, o_tri_v1z} <= 96'd0;
      {o_tri_v2x, o_tri_v2y, o_tri_v2z} <= 96'd0;
      o_poly_drawn   <= 1'b0;
    end else begin
      o_pf_vram_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_render_poly) begin
            o_busy      <= 1'b1;
            r_mode      <= w_dec_mode;
            r_mask      <= w_dec_mask;
            r_hmax      <= f_hmax(w_dec_mask);
            r_hdr_words <= w_dv ? 3'd5 : 3'd3;
            r_stride    <= w_dec_stride;
            r_prim_left <= i_opb_word[28:25];
            r_vaddr     <= i_poly_addr;
            r_word_idx  <= 2'd0;
            r_vcnt      <= 4'd0;
            if (w_dec_go) begin
              r_state        <= S_HDR;
              r_pending      <= 1'b1;
              o_pf_vram_rd   <= 1'b1;
              o_pf_vram_addr <= i_poly_addr;
            end else begin
              r_state      <= S_DONE;
              o_poly_drawn <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (r_pending && i_pf_vram_valid) begin
            case (r_word_idx)
              2'd0:    r_h0 <= i_pf_vram_din;
              2'd1:    r_h1 <= i_pf_vram_din;
              default: r_h2 <= i_pf_vram_din;
            endcase
            o_pf_vram_rd <= 1'b1;
            if (r_word_idx != 2'd2) begin
              r_word_idx     <= r_word_idx + 2'd1;
              o_pf_vram_addr <= w_word_addr_next;
            end else begin
              r_word_idx     <= 2'd0;
              r_vaddr        <= w_hdr_done_addr;
              o_pf_vram_addr <= w_hdr_done_addr;
              r_state        <= S_VTX;
            end
          end
        end
        S_VTX: begin
          if (r_pending && i_pf_vram_valid) begin
            case (r_word_idx)
              2'd0: begin
                r_nx           <= i_pf_vram_din;
                r_word_idx     <= 2'd1;
                o_pf_vram_rd   <= 1'b1;
                o_pf_vram_addr <= w_word_addr_next;
              end
              2'd1: begin
                r_ny           <= i_pf_vram_din;
                r_word_idx     <= 2'd2;
                o_pf_vram_rd   <= 1'b1;
                o_pf_vram_addr <= w_word_addr_next;
              end
              default: begin
                r_word_idx <= 2'd0;
                r_vaddr    <= w_vtx_done_addr;
                r_vcnt     <= r_vcnt + 4'd1;
                r_w1       <= r_w2;
                r_w2       <= w_new_vtx;
                if ((r_mode == M_QUAD) && (r_vcnt == 4'd0)) r_va <= w_new_vtx;
                if (w_emit) begin
                  r_pending   <= 1'b0;
                  r_state     <= S_EMIT;
                  o_tri_valid <= 1'b1;
                  {o_tri_isp, o_tri_tsp, o_tri_tcw} <= {r_h0, r_h1, r_h2};
                  {o_tri_v0x, o_tri_v0y, o_tri_v0z} <= w_t0;
                  {o_tri_v1x, o_tri_v1y, o_tri_v1z} <= w_t1;
                  {o_tri_v2x, o_tri_v2y, o_tri_v2z} <= w_new_vtx;
                end else begin
                  o_pf_vram_rd   <= 1'b1;
                  o_pf_vram_addr <= w_vtx_done_addr;
                end
              end
            endcase
          end
        end
        S_EMIT: begin
          if (i_tri_ready) begin
            o_tri_valid <= 1'b0;
            r_state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_next_done) begin
            r_state      <= S_DONE;
            o_poly_drawn <= 1'b1;
          end else if (w_next_hdr) begin
            r_state        <= S_HDR;
            r_vcnt         <= 4'd0;
            r_prim_left    <= r_prim_left - 4'd1;
            r_pending      <= 1'b1;
            o_pf_vram_rd   <= 1'b1;
            o_pf_vram_addr <= r_vaddr;
          end else begin
            r_state        <= S_VTX;
            r_pending      <= 1'b1;
            o_pf_vram_rd   <= 1'b1;
            o_pf_vram_addr <= r_vaddr;
          end
        end
        S_DONE: begin
          o_poly_drawn <= 1'b0;
          o_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
